// File: rtl/axi_r_resp_router_if.sv
// R-channel bundle for the response router: slave-side beat input plus the
// shared master-side payload with per-port valid/ready.
interface axi_r_resp_router_if #(
    parameter int ID_W   = 4,
    parameter int IDS_W  = 8,
    parameter int DATA_W = 32
);
    logic              s_rvalid;
    logic              s_rready;
    logic [IDS_W-1:0]  s_rid;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic [3:0]        m_rvalid;
    logic [3:0]        m_rready;
    logic [ID_W-1:0]   m_rid;
    logic [DATA_W-1:0] m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rlast;

    modport slave (
        input  s_rvalid, s_rid, s_rdata, s_rresp, s_rlast, m_rready,
        output s_rready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast
    );

    modport master (
        output s_rvalid, s_rid, s_rdata, s_rresp, s_rlast, m_rready,
        input  s_rready, m_rvalid, m_rid, m_rdata, m_rresp, m_rlast
    );
endinterface

// File: rtl/axi_r_resp_router.sv
// R-response router: strips the route field from extended IDs, buffers beats in a
// 2-entry skid buffer and steers them to one of 4 master ports. Optional RESP_ERR_CNT_EN.
//
// state    | meaning
// ---------+--------------------------------------------
// ST_EMPTY | no beat buffered
// ST_ONE   | head register holds the beat on m_*
// ST_FULL  | head + skid hold beats, input is stalled
module axi_r_resp_router #(
    parameter int ID_W   = 4,
    parameter int IDS_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rst,
    axi_r_resp_router_if.slave bus,
    output logic burst_active,
    output logic route_err
`ifdef RESP_ERR_CNT_EN
    ,
    output logic [15:0] resp_err_cnt
`endif
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic [1:0]        route;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    logic [1:0] state_q, state_d;
    beat_t      head_q, head_d;
    beat_t      skid_q, skid_d;
    beat_t      in_beat;
    logic       s_rready_q, s_rready_d;
    logic       burst_active_q, burst_active_d;
    logic [1:0] burst_route_q, burst_route_d;
    logic       route_err_q, route_err_d;
    logic       acc;
    logic       pop;
    logic       unused_rid_hi;

    assign unused_rid_hi = ^bus.s_rid[IDS_W-1:ID_W+2];

    assign in_beat = '{route: bus.s_rid[ID_W+1:ID_W],
                       id:    bus.s_rid[ID_W-1:0],
                       data:  bus.s_rdata,
                       resp:  bus.s_rresp,
                       last:  bus.s_rlast};

    assign bus.s_rready = s_rready_q;
    assign bus.m_rvalid = (state_q != ST_EMPTY) ? (4'b0001 << head_q.route) : 4'b0000;
    assign bus.m_rid    = head_q.id;
    assign bus.m_rdata  = head_q.data;
    assign bus.m_rresp  = head_q.resp;
    assign bus.m_rlast  = head_q.last;
    assign burst_active = burst_active_q;
    assign route_err    = route_err_q;

    assign acc = bus.s_rvalid & s_rready_q;
    assign pop = |(bus.m_rvalid & bus.m_rready);

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    head_d  = in_beat;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (acc && !pop) begin
                    skid_d  = in_beat;
                    state_d = ST_FULL;
                end else if (!acc && pop) begin
                    state_d = ST_EMPTY;
                end else if (acc && pop) begin
                    head_d = in_beat;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Registered ready looks ahead at the next occupancy, so m_rready never reaches s_rready combinationally.
        s_rready_d = (state_d != ST_FULL);
    end

    always_comb begin
        burst_active_d = burst_active_q;
        burst_route_d  = burst_route_q;
        route_err_d    = route_err_q;
        if (acc) begin
            if (!burst_active_q) begin
                burst_route_d  = in_beat.route;
                burst_active_d = !bus.s_rlast;
            end else begin
                if (in_beat.route != burst_route_q) begin
                    route_err_d = 1'b1;
                end
                if (bus.s_rlast) begin
                    burst_active_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_EMPTY;
            head_q         <= '0;
            skid_q         <= '0;
            s_rready_q     <= 1'b0;
            burst_active_q <= 1'b0;
            burst_route_q  <= 2'd0;
            route_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            head_q         <= head_d;
            skid_q         <= skid_d;
            s_rready_q     <= s_rready_d;
            burst_active_q <= burst_active_d;
            burst_route_q  <= burst_route_d;
            route_err_q    <= route_err_d;
        end
    end

`ifdef RESP_ERR_CNT_EN
    logic [15:0] resp_err_cnt_q, resp_err_cnt_d;

    always_comb begin
        resp_err_cnt_d = resp_err_cnt_q;
        if (pop && (head_q.resp != 2'b00) && (resp_err_cnt_q != 16'hFFFF)) begin
            resp_err_cnt_d = resp_err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_err_cnt_q <= 16'd0;
        end else begin
            resp_err_cnt_q <= resp_err_cnt_d;
        end
    end

    assign resp_err_cnt = resp_err_cnt_q;
`endif
endmodule

// File: tb/tb_axi_r_resp_router.sv
// Bench for axi_r_resp_router: directed scenarios then random traffic, every cycle
// checked against a queue-based model of the buffered beats and burst flags.
module tb_axi_r_resp_router;
    localparam int ID_W   = 4;
    localparam int IDS_W  = 8;
    localparam int DATA_W = 32;

    typedef struct {
        logic [7:0]  rid;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic burst_active;
    logic route_err;
`ifdef RESP_ERR_CNT_EN
    logic [15:0] resp_err_cnt;
`endif

    always #5 clk = ~clk;

    axi_r_resp_router_if #(.ID_W(ID_W), .IDS_W(IDS_W), .DATA_W(DATA_W)) bus ();

    axi_r_resp_router #(.ID_W(ID_W), .IDS_W(IDS_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .burst_active (burst_active),
        .route_err    (route_err)
`ifdef RESP_ERR_CNT_EN
        ,
        .resp_err_cnt (resp_err_cnt)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    beat_t      src_q[$];
    beat_t      exp_q[$];
    logic [3:0] rdy_drv  = 4'h0;
    bit         rst_seen = 1'b1;
    bit         b_active = 1'b0;
    logic [1:0] b_route  = 2'd0;
    bit         err      = 1'b0;
    int         cnt      = 0;
    int         acc_cnt  = 0;
    int         pop_cnt  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] rid, input logic [31:0] data,
                        input logic [1:0] resp, input logic last);
        beat_t b;
        b.rid  = rid;
        b.data = data;
        b.resp = resp;
        b.last = last;
        src_q.push_back(b);
    endtask

    // One clock: drive, check at negedge, advance the model across the next posedge.
    task automatic cycle();
        bit         exp_rdy;
        bit         acc;
        bit         pop;
        beat_t      h;
        logic [3:0] one_hot;
        logic [1:0] rt;
        if (src_q.size() > 0) begin
            bus.s_rvalid = 1'b1;
            bus.s_rid    = src_q[0].rid;
            bus.s_rdata  = src_q[0].data;
            bus.s_rresp  = src_q[0].resp;
            bus.s_rlast  = src_q[0].last;
        end else begin
            bus.s_rvalid = 1'b0;
            bus.s_rid    = '0;
            bus.s_rdata  = '0;
            bus.s_rresp  = '0;
            bus.s_rlast  = 1'b0;
        end
        bus.m_rready = rdy_drv;
        @(negedge clk);
        exp_rdy = !rst_seen && (exp_q.size() < 2);
        chk("s_rready", {63'd0, bus.s_rready}, {63'd0, exp_rdy});
        if (exp_q.size() > 0) begin
            h       = exp_q[0];
            one_hot = 4'b0001 << h.rid[5:4];
            chk("m_rvalid", {60'd0, bus.m_rvalid}, {60'd0, one_hot});
            chk("m_rid",    {60'd0, bus.m_rid},    {60'd0, h.rid[3:0]});
            chk("m_rdata",  {32'd0, bus.m_rdata},  {32'd0, h.data});
            chk("m_rresp",  {62'd0, bus.m_rresp},  {62'd0, h.resp});
            chk("m_rlast",  {63'd0, bus.m_rlast},  {63'd0, h.last});
        end else begin
            chk("m_rvalid_idle", {60'd0, bus.m_rvalid}, 64'd0);
        end
        if (rst_seen) begin
            chk("rst_payload", {bus.m_rid, bus.m_rdata, bus.m_rresp, bus.m_rlast}, 64'd0);
        end
        chk("burst_active", {63'd0, burst_active}, {63'd0, b_active});
        chk("route_err",    {63'd0, route_err},    {63'd0, err});
`ifdef RESP_ERR_CNT_EN
        chk("resp_err_cnt", {48'd0, resp_err_cnt}, 64'(cnt));
`endif
        if (rst) begin
            exp_q.delete();
            src_q.delete();
            b_active = 1'b0;
            b_route  = 2'd0;
            err      = 1'b0;
            cnt      = 0;
            rst_seen = 1'b1;
        end else begin
            acc = bus.s_rvalid && exp_rdy;
            pop = (exp_q.size() > 0) && rdy_drv[exp_q[0].rid[5:4]];
            if (pop) begin
                if (exp_q[0].resp != 2'b00 && cnt < 65535) cnt++;
                void'(exp_q.pop_front());
                pop_cnt++;
            end
            if (acc) begin
                h  = src_q.pop_front();
                rt = h.rid[5:4];
                if (!b_active) begin
                    b_route  = rt;
                    b_active = !h.last;
                end else begin
                    if (rt != b_route) err = 1'b1;
                    if (h.last) b_active = 1'b0;
                end
                exp_q.push_back(h);
                acc_cnt++;
            end
            rst_seen = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base_acc;
        int base_pop;
        bus.s_rvalid = 1'b0;
        bus.s_rid    = '0;
        bus.s_rdata  = '0;
        bus.s_rresp  = '0;
        bus.s_rlast  = 1'b0;
        bus.m_rready = 4'h0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 1'b0;

        // Single beat to route 2
        rdy_drv = 4'hF;
        push(8'h2A, 32'h1234_5678, 2'b00, 1'b1);
        repeat (3) cycle();

        // 4-beat burst to route 1 with port 1 stalled
        rdy_drv  = 4'b1101;
        base_acc = acc_cnt;
        base_pop = pop_cnt;
        for (int i = 0; i < 4; i++) push(8'h13, 32'hB000_0000 + i, 2'b00, (i == 3));
        repeat (5) cycle();
        chk("t2_accepted", 64'(acc_cnt - base_acc), 64'd2);
        chk("t2_stalled_ready", {63'd0, bus.s_rready}, 64'd0);
        rdy_drv = 4'hF;
        repeat (6) cycle();
        chk("t2_delivered", 64'(pop_cnt - base_pop), 64'd4);

        // Back-to-back single beats to routes 0, 3, 1, 2
        push(8'h01, 32'hC000_0000, 2'b00, 1'b1);
        push(8'h33, 32'hC000_0001, 2'b00, 1'b1);
        push(8'h15, 32'hC000_0002, 2'b00, 1'b1);
        push(8'h27, 32'hC000_0003, 2'b00, 1'b1);
        repeat (6) cycle();

        // Route change mid-burst
        push(8'h07, 32'hD000_0000, 2'b00, 1'b0);
        push(8'h39, 32'hD000_0001, 2'b00, 1'b0);
        push(8'h0C, 32'hD000_0002, 2'b00, 1'b1);
        repeat (6) cycle();
        chk("t4_route_err_sticky", {63'd0, route_err}, 64'd1);

        // Reset while FULL
        rdy_drv = 4'h0;
        push(8'h20, 32'hE000_0000, 2'b00, 1'b0);
        push(8'h21, 32'hE000_0001, 2'b00, 1'b0);
        push(8'h22, 32'hE000_0002, 2'b00, 1'b0);
        repeat (4) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
        chk("t5_ready_after_rst", {63'd0, bus.s_rready}, 64'd1);

        // Error responses
        rdy_drv = 4'hF;
        push(8'h11, 32'hF000_0000, 2'b00, 1'b1);
        push(8'h22, 32'hF000_0001, 2'b10, 1'b1);
        push(8'h33, 32'hF000_0002, 2'b11, 1'b1);
        repeat (5) cycle();
`ifdef RESP_ERR_CNT_EN
        chk("t6_resp_err_cnt", {48'd0, resp_err_cnt}, 64'd2);
`endif

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if (src_q.size() < 2 && $urandom_range(0, 3) != 0) begin
                push(8'($urandom), $urandom, 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) == 0));
            end
            rdy_drv = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            rst     = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;
        rdy_drv = 4'hF;
        repeat (4) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
